qoa_sample_fifo_pwm: RTL and testbench

- Downstream consumer of the QOA decoder's sample/sample_valid output.
- Buffers decoded signed 16-bit PCM samples in a small FIFO and drains them at a fixed, clock-derived sample rate.
- Each drained sample drives a single-pin PWM DAC output.
- Reports FIFO occupancy and full status back to the host-side control logic, which uses them to pace SPI traffic.

---
 rtl/qoa_sample_fifo_pwm.sv | 115 +++++++++++
 tb/tb_qoa_sample_fifo_pwm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qoa_sample_fifo_pwm.sv
// Sample FIFO plus PWM DAC for decoded QOA PCM. Samples are buffered and drained
// one per PWM sample period; each sample sets the PWM duty cycle.
module qoa_sample_fifo_pwm #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned REPEAT   = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     enable,
  input  logic [15:0]              sample_in,
  input  logic                     sample_valid,
  input  logic                     clear_flags,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underrun,
  output logic                     pwm_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [RW-1:0]       REP_LAST = RW'(REPEAT - 1);
  localparam logic [LW-1:0]       LVL_FULL = LW'(DEPTH);

  // Entries hold the already-converted duty value, not the raw sample.
  logic [PWM_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [PWM_BITS-1:0] cnt;
  logic [RW-1:0]       rep;
  logic [PWM_BITS-1:0] duty;

  logic                boundary_c;
  logic                pop_c;
  logic                push_c;
  logic                drop_c;
  logic [LW-1:0]       level_next_c;
  logic [PWM_BITS-1:0] duty_in_c;
  logic                unused_lsbs;

  // Signed to offset-binary by truncation to the top PWM_BITS bits.
  assign duty_in_c   = {~sample_in[15], sample_in[14 -: PWM_BITS-1]};
  assign unused_lsbs = ^sample_in[15-PWM_BITS:0];

  assign boundary_c = enable && (cnt == CNT_LAST) && (rep == REP_LAST);
  assign pop_c      = boundary_c && !fifo_empty;
  assign push_c     = sample_valid && ((level != LVL_FULL) || pop_c);
  assign drop_c     = sample_valid && !push_c;

  always_comb begin
    level_next_c = level;
    case ({push_c, pop_c})
      2'b10:   level_next_c = level + 1'b1;
      2'b01:   level_next_c = level - 1'b1;
      default: level_next_c = level;
    endcase
  end

  // Storage array carries no reset; the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push_c && !sys_rst) begin
      mem[wptr] <= duty_in_c;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      cnt        <= '0;
      rep        <= '0;
      duty       <= DUTY_MID;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      pwm_out    <= 1'b0;
    end else begin
      if (push_c) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_c) begin
        rptr <= rptr + 1'b1;
        duty <= mem[rptr];
      end
      level      <= level_next_c;
      fifo_full  <= (level_next_c == LVL_FULL);
      fifo_empty <= (level_next_c == '0);

      // Period counters only run while enabled; re-enable starts at cnt=0.
      if (enable) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          rep <= (rep == REP_LAST) ? '0 : rep + 1'b1;
        end
      end else begin
        cnt <= '0;
        rep <= '0;
      end

      // Set beats clear when both happen in the same cycle.
      overflow <= drop_c | (overflow & ~clear_flags);
      underrun <= (boundary_c & fifo_empty) | (underrun & ~clear_flags);
      pwm_out  <= enable & (cnt < duty);
    end
  end

endmodule

// File: tb/tb_qoa_sample_fifo_pwm.sv
// Bench for qoa_sample_fifo_pwm: a queue of expected duties is filled on writes
// and drained at each sample boundary, then matched against measured PWM high time.
module tb_qoa_sample_fifo_pwm;

  localparam int unsigned DEPTH = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        clear_flags = 1'b0;

  logic       full1, empty1, ovf1, und1, pwm1;
  logic [3:0] level1;
  logic       full2, empty2, ovf2, und2, pwm2;
  logic [3:0] level2;

  logic       sel2 = 1'b0;
  logic       o_full, o_empty, o_ovf, o_und, o_pwm;
  logic [3:0] o_level;

  always #5 sys_clk = ~sys_clk;

  qoa_sample_fifo_pwm dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
    .sample_in(sample_in), .sample_valid(sample_valid), .clear_flags(clear_flags),
    .fifo_full(full1), .fifo_empty(empty1), .level(level1),
    .overflow(ovf1), .underrun(und1), .pwm_out(pwm1)
  );

  qoa_sample_fifo_pwm #(.REPEAT(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
    .sample_in(sample_in), .sample_valid(sample_valid), .clear_flags(clear_flags),
    .fifo_full(full2), .fifo_empty(empty2), .level(level2),
    .overflow(ovf2), .underrun(und2), .pwm_out(pwm2)
  );

  always_comb begin
    o_full  = sel2 ? full2  : full1;
    o_empty = sel2 ? empty2 : empty1;
    o_level = sel2 ? level2 : level1;
    o_ovf   = sel2 ? ovf2   : ovf1;
    o_und   = sel2 ? und2   : und1;
    o_pwm   = sel2 ? pwm2   : pwm1;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cur_duty = 8'd128;
  logic       m_ovf = 1'b0;
  logic       m_und = 1'b0;

  function automatic logic [7:0] duty_of(input logic [15:0] s);
    logic [15:0] t;
    t = (s >> 8) ^ 16'h0080;
    return t[7:0];
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    sample_valid = 1'b0;
    clear_flags = 1'b0;
    tick();
    sys_rst = 1'b0;
    exp_q.delete();
    cur_duty = 8'd128;
    m_ovf = 1'b0;
    m_und = 1'b0;
  endtask

  // Only used while enable=0, so no pops can race the write.
  task automatic write(input logic [15:0] s);
    sample_in = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(duty_of(s));
    else m_ovf = 1'b1;
  endtask

  // One full sample period; optional write/clear land in the boundary cycle.
  task automatic run_period(input int plen, input bit bw, input logic [15:0] bs,
                            input bit bc, output int hi, output int exp_hi);
    hi = 0;
    exp_hi = int'(cur_duty) * (plen / 256);
    for (int i = 0; i < plen; i++) begin
      if (i == plen - 1) begin
        sample_in = bs;
        sample_valid = bw;
        clear_flags = bc;
      end
      tick();
      sample_valid = 1'b0;
      clear_flags = 1'b0;
      hi += int'(o_pwm);
    end
    if (bc) begin
      m_ovf = 1'b0;
      m_und = 1'b0;
    end
    if (exp_q.size() > 0) cur_duty = exp_q.pop_front();
    else m_und = 1'b1;
    if (bw) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(duty_of(bs));
      else m_ovf = 1'b1;
    end
  endtask

  task automatic test_reset();
    sel2 = 1'b0;
    enable = 1'b0;
    do_reset();
    checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", o_level); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", o_empty); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", o_ovf); end
    checks++; if (o_und !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", o_und); end
    checks++; if (o_pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b exp 0", o_pwm); end
  endtask

  task automatic test_idle();
    int hi, eh;
    enable = 1'b1;
    for (int p = 0; p < 2; p++) begin
      run_period(256, 1'b0, 16'h0, 1'b0, hi, eh);
      checks++; if (hi !== 128) begin errors++; $display("FAIL idle_high p%0d got %0d exp 128", p, hi); end
      checks++; if (o_und !== 1'b1) begin errors++; $display("FAIL idle_underrun p%0d got %b exp 1", p, o_und); end
    end
    enable = 1'b0;
    tick();
    checks++; if (o_pwm !== 1'b0) begin errors++; $display("FAIL idle_disable_pwm got %b exp 0", o_pwm); end
  endtask

  task automatic test_sequence();
    int hi, eh;
    do_reset();
    write(16'h7FFF);
    write(16'h8000);
    write(16'h0000);
    checks++; if (o_level !== 4'd3) begin errors++; $display("FAIL seq_level_init got %0d exp 3", o_level); end
    enable = 1'b1;
    for (int p = 0; p < 4; p++) begin
      run_period(256, 1'b0, 16'h0, 1'b0, hi, eh);
      checks++; if (hi !== eh) begin errors++; $display("FAIL seq_high p%0d got %0d exp %0d", p, hi, eh); end
      checks++; if (o_level !== 4'(exp_q.size())) begin errors++; $display("FAIL seq_level p%0d got %0d exp %0d", p, o_level, exp_q.size()); end
      checks++; if (o_und !== m_und) begin errors++; $display("FAIL seq_underrun p%0d got %b exp %b", p, o_und, m_und); end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_overflow_clear();
    int hi, eh;
    for (int i = 0; i < 9; i++) begin
      write(16'(i * 32'h1D00 + 32'h0345));
      checks++; if (o_level !== 4'(exp_q.size())) begin errors++; $display("FAIL ovf_level w%0d got %0d exp %0d", i, o_level, exp_q.size()); end
      checks++; if (o_ovf !== m_ovf) begin errors++; $display("FAIL ovf_flag w%0d got %b exp %b", i, o_ovf, m_ovf); end
    end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", o_full); end
    checks++; if (o_und !== 1'b1) begin errors++; $display("FAIL ovf_underrun_held got %b exp 1", o_und); end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    m_ovf = 1'b0;
    m_und = 1'b0;
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL clear_overflow got %b exp 0", o_ovf); end
    checks++; if (o_und !== 1'b0) begin errors++; $display("FAIL clear_underrun got %b exp 0", o_und); end
    enable = 1'b1;
    run_period(256, 1'b1, 16'h1234, 1'b0, hi, eh);
    checks++; if (hi !== eh) begin errors++; $display("FAIL bnd_high got %0d exp %0d", hi, eh); end
    checks++; if (o_level !== 4'd8) begin errors++; $display("FAIL bnd_level got %0d exp 8", o_level); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL bnd_overflow got %b exp 0", o_ovf); end
    for (int p = 1; p < 10; p++) begin
      run_period(256, 1'b0, 16'h0, (p == 9), hi, eh);
      checks++; if (hi !== eh) begin errors++; $display("FAIL play_high p%0d got %0d exp %0d", p, hi, eh); end
      checks++; if (o_level !== 4'(exp_q.size())) begin errors++; $display("FAIL play_level p%0d got %0d exp %0d", p, o_level, exp_q.size()); end
      checks++; if (o_und !== m_und) begin errors++; $display("FAIL play_underrun p%0d got %b exp %b", p, o_und, m_und); end
    end
    enable = 1'b0;
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    checks++; if (o_und !== 1'b0) begin errors++; $display("FAIL clear_after_coincident got %b exp 0", o_und); end
  endtask

  task automatic test_repeat_reset();
    int hi, eh;
    sel2 = 1'b1;
    enable = 1'b0;
    do_reset();
    write(16'h4000);
    write(16'hC000);
    enable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      run_period(512, 1'b0, 16'h0, 1'b0, hi, eh);
      checks++; if (hi !== eh) begin errors++; $display("FAIL rep_high p%0d got %0d exp %0d", p, hi, eh); end
      checks++; if (o_level !== 4'(exp_q.size())) begin errors++; $display("FAIL rep_level p%0d got %0d exp %0d", p, o_level, exp_q.size()); end
    end
    checks++; if (o_und !== 1'b1) begin errors++; $display("FAIL rep_underrun got %b exp 1", o_und); end
    for (int i = 0; i < 100; i++) tick();
    do_reset();
    checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL midrst_level got %0d exp 0", o_level); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b exp 1", o_empty); end
    checks++; if (o_pwm !== 1'b0) begin errors++; $display("FAIL midrst_pwm got %b exp 0", o_pwm); end
    checks++; if (o_und !== 1'b0) begin errors++; $display("FAIL midrst_underrun got %b exp 0", o_und); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b exp 0", o_ovf); end
    run_period(512, 1'b0, 16'h0, 1'b0, hi, eh);
    checks++; if (hi !== 256) begin errors++; $display("FAIL midrst_high got %0d exp 256", hi); end
    checks++; if (o_und !== 1'b1) begin errors++; $display("FAIL midrst_underrun_after got %b exp 1", o_und); end
    enable = 1'b0;
    sel2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_sequence();
    test_overflow_clear();
    test_repeat_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
